// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for up to 8 requesters with a registered one-hot grant held until release.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_8 #(
  parameter int unsigned N        = 8,
  parameter int unsigned ID_W     = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic            any_req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            timeout
);

  if (N < 2 || N > 8 || (1 << ID_W) < N || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
    $error("rr_arbiter_8: illegal parameter set");
  end

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]    gnt_d;
  logic [ID_W-1:0] gnt_id_d;
  logic            busy_d;
  logic            owner_req;
  logic            hold_expired;
  logic            forced;
  logic            arb;
  logic [ID_W-1:0] start;
  logic [ID_W-1:0] next_ptr;
  logic [N-1:0]    cand;
  logic [ID_W:0]   pick;

  // First set bit of r searching upward from start with wrap; MSB of result is the found flag.
  function automatic logic [ID_W:0] rr_pick(input logic [N-1:0] r, input logic [ID_W-1:0] from);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    int unsigned     j;
    res = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(from) + i;
      if (j >= N) j = j - N;
      idx = ID_W'(j);
      if (!res[ID_W] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign any_req   = |req;
  assign owner_req = req[gnt_id];
  assign next_ptr  = (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + ID_W'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;

  assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign timeout      = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // Next-state and grant selection
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    busy_d   = busy;
    start    = ptr_q;
    cand     = req;
    arb      = 1'b0;
    forced   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      IDLE: arb = any_req;
      BUSY: begin
        if (!owner_req || hold_expired) begin
          forced = owner_req;
          ptr_d  = next_ptr;
          start  = next_ptr;
          arb    = 1'b1;
          // A timed-out owner sits out the re-arbitration on the release edge
          if (forced) cand = req & ~gnt;
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    pick = rr_pick(cand, start);
    if (arb) begin
      if (pick[ID_W]) begin
        state_d  = BUSY;
        gnt_d    = N'(1) << pick[ID_W-1:0];
        gnt_id_d = pick[ID_W-1:0];
        busy_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = '0;
`endif
      end else begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      busy    <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= forced;
    end
  end
`endif

endmodule
